lcd_refresh_ctrl: RTL and testbench

HD44780-compatible 16x2 character-LCD controller sitting directly downstream of the square-root datapath and its result-to-ASCII formatting. It runs the power-up initialisation, then on each refresh request reads a 32-character buffer and writes it to both display lines. It drives the board LCD pins directly.

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_write_phy.sv | 98 +++++++++
 rtl/lcd_refresh_ctrl.sv | 155 +++++++++++++++
 tb/tb_lcd_refresh_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared command constants and state types for the HD44780 16x2 refresh controller.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC  = 8'h38; // 8-bit bus, two lines, 5x8 font
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_CLR   = 8'h01;
    localparam logic [7:0] CMD_L1    = 8'h80;
    localparam logic [7:0] CMD_L2    = 8'hC0;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_L1CMD,
        ST_FETCH,
        ST_CAPT,
        ST_CHAR,
        ST_L2CMD,
        ST_FIN
    } lcd_state_t;

    typedef enum logic [1:0] {
        PHY_IDLE,
        PHY_SETUP,
        PHY_EHI,
        PHY_WAIT
    } phy_state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return CMD_FUNC;
            2'd1:    return CMD_DISP;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_write_phy.sv
// One HD44780 byte write: setup, E pulse, post-strobe wait, then a one-cycle rdy.
module lcd_write_phy
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int E_PW_CYC  = 12,
    parameter int CMD_CYC   = 2000,
    parameter int CLR_CYC   = 82000,
    parameter int CNT_W     = 18
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       go,
    input  logic       rs,
    input  logic [7:0] wr_byte,
    input  logic       long_wait,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] data_lcd,
    output logic       rdy
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EPW_LAST   = CNT_W'(E_PW_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYC - 1);

    phy_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             long_q;
    logic             e_nxt, rdy_nxt, load;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        e_nxt     = 1'b0;
        rdy_nxt   = 1'b0;
        load      = 1'b0;
        unique case (state)
            PHY_IDLE: begin
                cnt_nxt = '0;
                if (go) begin
                    load      = 1'b1;
                    state_nxt = PHY_SETUP;
                end
            end
            PHY_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    e_nxt     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = PHY_EHI;
                end
            end
            PHY_EHI: begin
                e_nxt = 1'b1;
                if (cnt == EPW_LAST) begin
                    e_nxt     = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = PHY_WAIT;
                end
            end
            PHY_WAIT: begin
                if (cnt == (long_q ? CLR_LAST : CMD_LAST)) begin
                    rdy_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = PHY_IDLE;
                end
            end
            default: state_nxt = PHY_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= PHY_IDLE;
            cnt      <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            data_lcd <= 8'h00;
            long_q   <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lcd_e <= e_nxt;
            rdy   <= rdy_nxt;
            // RS/DATA load only at go, so they cannot move while E is high.
            if (load) begin
                lcd_rs   <= rs;
                data_lcd <= wr_byte;
                long_q   <= long_wait;
            end
        end
    end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 controller: power-up init, then on request copies a 32-byte buffer to both lines.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC = 750000,
    parameter int SETUP_CYC = 2,
    parameter int E_PW_CYC  = 12,
    parameter int CMD_CYC   = 2000,
    parameter int CLR_CYC   = 82000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic [4:0] char_addr_o,
    input  logic [7:0] char_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_on,
    output logic       lcd_blon,
    output logic [7:0] data_lcd
);

    localparam int CNT_W = $clog2(CLR_CYC > PWRUP_CYC ? CLR_CYC : PWRUP_CYC) + 1;
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);

    lcd_state_t       state, state_nxt;
    logic [CNT_W-1:0] pwr_cnt;
    logic [4:0]       idx, idx_nxt;
    logic             sent, pending, pending_nxt;
    logic [7:0]       char_q;
    logic             go, phy_rs, long_wait, rdy;
    logic [7:0]       wr_byte;

    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;
    assign lcd_blon = 1'b1;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        go        = 1'b0;
        phy_rs    = 1'b0;
        long_wait = 1'b0;
        wr_byte   = char_q;
        unique case (state)
            ST_PWRUP: if (pwr_cnt == PWRUP_LAST) state_nxt = ST_INIT;
            ST_INIT: begin
                wr_byte   = init_cmd(idx[1:0]);
                long_wait = (idx[1:0] == 2'd3);
                go        = !sent;
                if (rdy) begin
                    if (idx[1:0] == 2'd3) begin
                        idx_nxt   = 5'd0;
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            ST_IDLE: if (start_i || pending) state_nxt = ST_L1CMD;
            ST_L1CMD: begin
                wr_byte = CMD_L1;
                go      = !sent;
                if (rdy) begin
                    idx_nxt   = 5'd0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_CAPT;
            ST_CAPT:  state_nxt = ST_CHAR;
            ST_CHAR: begin
                phy_rs = 1'b1;
                go     = !sent;
                if (rdy) begin
                    if (idx == 5'd15) begin
                        state_nxt = ST_L2CMD;
                    end else if (idx == 5'd31) begin
                        state_nxt = ST_FIN;
                    end else begin
                        idx_nxt   = idx + 5'd1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_L2CMD: begin
                wr_byte = CMD_L2;
                go      = !sent;
                if (rdy) begin
                    idx_nxt   = 5'd16;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FIN: begin
                idx_nxt   = 5'd0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_PWRUP;
        endcase
    end

    // Single request slot: accepting a refresh consumes it, any start while busy refills it.
    always_comb begin
        pending_nxt = pending;
        if (state == ST_IDLE && state_nxt == ST_L1CMD) pending_nxt = 1'b0;
        else if (start_i && busy_o)                    pending_nxt = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_PWRUP;
            pwr_cnt     <= '0;
            idx         <= 5'd0;
            sent        <= 1'b0;
            pending     <= 1'b0;
            char_q      <= 8'h00;
            char_addr_o <= 5'd0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            pending <= pending_nxt;
            pwr_cnt <= (state == ST_PWRUP) ? pwr_cnt + CNT_W'(1) : '0;
            if (go)       sent <= 1'b1;
            else if (rdy) sent <= 1'b0;
            if (state == ST_CAPT) char_q <= char_data_i;
            if (state_nxt == ST_FETCH) char_addr_o <= idx_nxt;
            busy_o <= (state_nxt != ST_IDLE);
            done_o <= (state_nxt == ST_FIN);
        end
    end

    lcd_write_phy #(
        .SETUP_CYC (SETUP_CYC),
        .E_PW_CYC  (E_PW_CYC),
        .CMD_CYC   (CMD_CYC),
        .CLR_CYC   (CLR_CYC),
        .CNT_W     (CNT_W)
    ) u_phy (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .go        (go),
        .rs        (phy_rs),
        .wr_byte   (wr_byte),
        .long_wait (long_wait),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .data_lcd  (data_lcd),
        .rdy       (rdy)
    );

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl with a bus monitor and a 1-cycle-latency buffer model.
module tb_lcd_refresh_ctrl;

    localparam int PWRUP_CYC = 20;
    localparam int SETUP_CYC = 2;
    localparam int E_PW_CYC  = 3;
    localparam int CMD_CYC   = 5;
    localparam int CLR_CYC   = 10;

    // E-low gap between consecutive commands: wait + rdy cycle + go cycle + setup.
    localparam int CMD_GAP   = CMD_CYC + 2 + SETUP_CYC;
    // From reset release to first E rise: power-up + go cycle + setup.
    localparam int FIRST_GAP = PWRUP_CYC + 1 + SETUP_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic       busy, done, lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_blon;
    logic [7:0] data_lcd;

    logic [7:0] mem [32];

    int total = 0;
    int bad   = 0;

    lcd_refresh_ctrl #(
        .PWRUP_CYC (PWRUP_CYC),
        .SETUP_CYC (SETUP_CYC),
        .E_PW_CYC  (E_PW_CYC),
        .CMD_CYC   (CMD_CYC),
        .CLR_CYC   (CLR_CYC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .char_addr_o (char_addr),
        .char_data_i (char_data),
        .busy_o      (busy),
        .done_o      (done),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_on      (lcd_on),
        .lcd_blon    (lcd_blon),
        .data_lcd    (data_lcd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) char_data <= mem[char_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor, sampled on the falling edge.
    int         cyc = 0;
    int         rise_cyc = 0, fall_cyc = 0, last_chg = 0;
    int         done_cnt = 0, done_cyc = 0, busy_fall_cyc = 0;
    logic       e_prev = 1'b0, done_prev = 1'b0, busy_prev = 1'b1;
    logic [8:0] bus_prev = '0;
    logic [8:0] pulses [$];
    int         gaps [$];

    always @(negedge clk) begin
        cyc++;
        check("rw_zero", 32'(lcd_rw), 32'd0);
        if (rst) begin
            fall_cyc = cyc;
        end else begin
            if (lcd_e && e_prev) check("bus_stable_e_high", 32'({lcd_rs, data_lcd}), 32'(bus_prev));
            if ({lcd_rs, data_lcd} !== bus_prev) last_chg = cyc;
            if (lcd_e && !e_prev) begin
                rise_cyc = cyc;
                check("setup_min", 32'(cyc - last_chg >= SETUP_CYC), 32'd1);
                pulses.push_back({lcd_rs, data_lcd});
                gaps.push_back(cyc - fall_cyc);
            end
            if (!lcd_e && e_prev) begin
                check("e_width", 32'(cyc - rise_cyc), 32'(E_PW_CYC));
                fall_cyc = cyc;
            end
            if (done) begin
                check("done_single_cycle", 32'(done_prev), 32'd0);
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy_prev && !busy) busy_fall_cyc = cyc;
        end
        e_prev    = lcd_e;
        bus_prev  = {lcd_rs, data_lcd};
        done_prev = done;
        busy_prev = busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        while (pulses.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("pulse_count_reached", 32'(pulses.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check("done_count_reached", 32'(done_cnt), 32'(target));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_lines(input string l1, input string l2);
        for (int i = 0; i < 16; i++) begin
            mem[i]      = (i < l1.len()) ? l1[i] : 8'h20;
            mem[16 + i] = (i < l2.len()) ? l2[i] : 8'h20;
        end
    endtask

    task automatic check_init(input string tag);
        logic [7:0] cmds [4];
        cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
        for (int i = 0; i < 4; i++) check({tag, "_cmd"}, 32'(pulses[i]), 32'({1'b0, cmds[i]}));
        check({tag, "_gap_pwrup"}, 32'(gaps[0]), 32'(FIRST_GAP));
        for (int i = 1; i < 4; i++) check({tag, "_gap_cmd"}, 32'(gaps[i]), 32'(CMD_GAP));
    endtask

    task automatic check_refresh(input int base, input logic [7:0] exp_mem [32]);
        check("l1_cmd", 32'(pulses[base]), 32'({1'b0, 8'h80}));
        for (int i = 0; i < 16; i++) check("l1_char", 32'(pulses[base + 1 + i]), 32'({1'b1, exp_mem[i]}));
        check("l2_cmd", 32'(pulses[base + 17]), 32'({1'b0, 8'hC0}));
        for (int i = 16; i < 32; i++) check("l2_char", 32'(pulses[base + 2 + i]), 32'({1'b1, exp_mem[i]}));
    endtask

    initial begin
        logic [7:0] snap [32];
        int         base;
        int         k;

        rst   = 1'b1;
        start = 1'b0;
        load_lines("", "");
        tick();
        tick();

        // Reset state
        check("rst_e", 32'(lcd_e), 32'd0);
        check("rst_rs", 32'(lcd_rs), 32'd0);
        check("rst_rw", 32'(lcd_rw), 32'd0);
        check("rst_data", 32'(data_lcd), 32'h00);
        check("rst_on", 32'(lcd_on), 32'd1);
        check("rst_blon", 32'(lcd_blon), 32'd1);
        check("rst_addr", 32'(char_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_done", 32'(done), 32'd0);

        // Power-up and init sequence
        rst = 1'b0;
        wait_pulses(4, 200);
        check_init("init");
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        check("init_busy_fall", 32'(busy_fall_cyc - fall_cyc), 32'(CLR_CYC + 1));
        check("init_no_done", 32'(done_cnt), 32'd0);
        check("init_pulses", 32'(pulses.size()), 32'd4);

        // Full refresh
        load_lines("SQRT(65535)=", "255.99");
        snap = mem;
        pulses.delete();
        gaps.delete();
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(1, 2000);
        check("done_busy_high", 32'(busy), 32'd1);
        check("done_after_last_rdy", 32'(done_cyc - fall_cyc), 32'(CMD_CYC + 1));
        tick();
        check("busy_low_after_done", 32'(busy), 32'd0);
        repeat (20) tick();
        check("refresh_pulses", 32'(pulses.size()), 32'd34);
        check("refresh_done_once", 32'(done_cnt), 32'd1);
        check_refresh(0, snap);

        // Buffer changes around the fetch of char 5
        mem[5] = "A";
        mem[6] = "B";
        pulses.delete();
        pulse_start();
        k = 0;
        while (char_addr != 5'd5 && k < 2000) begin
            tick();
            k++;
        end
        check("reach_fetch5", 32'(char_addr), 32'd5);
        tick();
        mem[5] = "Z";
        mem[6] = "Q";
        wait_done(2, 2000);
        check("char5_fetch_value", 32'(pulses[6]), 32'({1'b1, 8'h41}));
        check("char6_fetch_value", 32'(pulses[7]), 32'({1'b1, 8'h51}));

        // start held high: back-to-back refreshes with one idle cycle
        repeat (5) tick();
        base  = done_cnt;
        start = 1'b1;
        wait_done(base + 1, 2000);
        tick();
        check("b2b_idle_cycle", 32'(busy), 32'd0);
        tick();
        check("b2b_restart", 32'(busy), 32'd1);
        repeat (5) tick();
        start = 1'b0;
        wait_done(base + 3, 4000);
        repeat (600) tick();
        check("b2b_done_total", 32'(done_cnt), 32'(base + 3));
        check("b2b_quiet", 32'(busy), 32'd0);

        // Three starts mid-refresh merge into one extra refresh
        base = done_cnt;
        pulse_start();
        repeat (100) tick();
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            repeat (10) tick();
        end
        wait_done(base + 2, 3000);
        repeat (600) tick();
        check("merge_done_total", 32'(done_cnt), 32'(base + 2));
        check("merge_quiet", 32'(busy), 32'd0);

        // Reset during E high of char 7, then starts during power-up/init
        pulse_start();
        k = 0;
        while (!(char_addr == 5'd7 && lcd_e) && k < 2000) begin
            tick();
            k++;
        end
        check("reach_char7_e", 32'({char_addr, lcd_e}), 32'({5'd7, 1'b1}));
        rst = 1'b1;
        #1;
        check("abort_e_low", 32'(lcd_e), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_data", 32'(data_lcd), 32'h00);
        tick();
        tick();
        base = done_cnt;
        pulses.delete();
        gaps.delete();
        rst = 1'b0;
        repeat (5) tick();
        pulse_start();
        repeat (10) tick();
        pulse_start();
        repeat (20) tick();
        pulse_start();
        wait_pulses(4, 200);
        check_init("reinit");
        check("reinit_no_done", 32'(done_cnt), 32'(base));
        wait_done(base + 1, 2000);
        repeat (600) tick();
        check("reinit_one_refresh", 32'(done_cnt), 32'(base + 1));
        check("reinit_pulses", 32'(pulses.size()), 32'd38);
        check("reinit_quiet", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
